// File: rtl/ifetch_buf_if.sv
// Fetch-buffer bus: PC stream in, ROM port, redirect port and decode handshake.
// The master modport is the fetch buffer itself; slave is its environment.
interface ifetch_buf_if;
  logic [31:0] pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        ex_jump_en_i;
  logic [31:0] ex_jump_addr_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  modport master (
    input  pc_i, imem_rdata_i, ex_jump_en_i, ex_jump_addr_i, inst_ready_i,
    output imem_addr_o, jump_en_o, jump_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  modport slave (
    output pc_i, imem_rdata_i, ex_jump_en_i, ex_jump_addr_i, inst_ready_i,
    input  imem_addr_o, jump_en_o, jump_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: queues ROM returns for decode, replays dropped
// addresses as jumps when full, forwards execute redirects and flushes.
// Optional macro IFETCH_BYPASS_EN: an arrival into an empty buffer is
// presented to decode in the same cycle.
module ifetch_buf #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  ifetch_buf_if.master bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;

  // Fetch-stage tracking of the address whose data returns this cycle
  logic [XLEN-1:0] f1_pc, f1_pc_n;
  logic            f1_valid, f1_valid_n;

  // FIFO storage and bookkeeping
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_addr [DEPTH];
  logic [AW-1:0]   rd_ptr, rd_ptr_n;
  logic [AW-1:0]   wr_ptr, wr_ptr_n;
  logic [CW-1:0]   count, count_n;

  logic arrival, ex_hit, empty, full, bypass;
  logic head_valid, pop, replay, redirect, push, fifo_pop, fifo_wr;

  // Handshake decisions, redirect generation and next-state computation
  always_comb begin
    arrival  = f1_valid;
    ex_hit   = bus.ex_jump_en_i & ~rst;
    empty    = (count == CW'(0));
    full     = (count == CW'(DEPTH));
`ifdef IFETCH_BYPASS_EN
    bypass   = empty & arrival & ~ex_hit & ~rst;
`else
    bypass   = 1'b0;
`endif
    // Head is hidden during a redirect so no wrong-path entry is consumed
    head_valid = ~rst & ~ex_hit & (~empty | bypass);
    pop        = head_valid & bus.inst_ready_i;
    replay     = ~rst & arrival & full & ~pop & ~bus.ex_jump_en_i;
    redirect   = ex_hit | replay;
    push       = arrival & ~redirect & (~full | pop);
    fifo_pop   = pop & ~empty;
    // A bypassed arrival that decode takes is never stored
    fifo_wr    = push & ~(bypass & pop);

    bus.imem_addr_o  = bus.pc_i;
    bus.jump_en_o    = redirect;
    bus.jump_addr_o  = ex_hit ? bus.ex_jump_addr_i : f1_pc;
    bus.inst_valid_o = head_valid;
    bus.inst_o       = bypass ? bus.imem_rdata_i : mem_inst[rd_ptr];
    bus.inst_addr_o  = bypass ? f1_pc : mem_addr[rd_ptr];

    f1_pc_n    = bus.pc_i;
    f1_valid_n = ~redirect;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    count_n    = count;
    if (ex_hit) begin
      rd_ptr_n = AW'(0);
      wr_ptr_n = AW'(0);
      count_n  = CW'(0);
    end else begin
      if (fifo_wr)  wr_ptr_n = wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr_n = rd_ptr + AW'(1);
      count_n = count + CW'(fifo_wr) - CW'(fifo_pop);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      f1_pc    <= '0;
      f1_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      f1_pc    <= f1_pc_n;
      f1_valid <= f1_valid_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
    end
  end

  // FIFO storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (fifo_wr && !rst) begin
      mem_inst[wr_ptr] <= bus.imem_rdata_i;
      mem_addr[wr_ptr] <= f1_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: PC register and ROM models drive the DUT, a
// queue-based reference predicts every output each cycle.
module tb_ifetch_buf;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [31:0] pc;
  int total = 0;
  int bad   = 0;

  ifetch_buf_if bus ();

  ifetch_buf #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // PC register (no stall, redirectable) and one-cycle-latency ROM
  assign bus.pc_i = pc;
  always @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else if (bus.jump_en_o) pc <= bus.jump_addr_o;
    else pc <= pc + 32'd4;
    bus.imem_rdata_i <= bus.imem_addr_o ^ KEY;
  end

  // Reference state: buffered addresses plus the in-flight fetch
  logic [31:0] mq[$];
  bit          m_f1v;
  logic [31:0] m_f1pc;
  logic [31:0] exp_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit ex, input logic [31:0] exa);
    bit arr, full, byp, v, pop, rep, jmp, push;
    logic [31:0] head, ja;
    @(negedge clk);
    rst = r;
    bus.inst_ready_i   = rdy;
    bus.ex_jump_en_i   = ex;
    bus.ex_jump_addr_i = exa;
    #1;
    if (r) begin
      check("rst_valid", 32'(bus.inst_valid_o), 32'h0);
      check("rst_jump",  32'(bus.jump_en_o),    32'h0);
      mq.delete();
      m_f1v    = 1'b0;
      exp_next = 32'h0;
      return;
    end
    arr  = m_f1v;
    full = (mq.size() == DEPTH);
    byp  = BYP && (mq.size() == 0) && arr && !ex;
    v    = !ex && (mq.size() != 0 || byp);
    head = (mq.size() != 0) ? mq[0] : m_f1pc;
    pop  = v && rdy;
    rep  = arr && full && !pop && !ex;
    jmp  = ex || rep;
    ja   = ex ? exa : m_f1pc;
    push = arr && !jmp && (!full || pop);

    check("count",     32'(dut.count),        32'(mq.size()));
    check("imem_addr", bus.imem_addr_o,       pc);
    check("valid",     32'(bus.inst_valid_o), 32'(v));
    check("jump_en",   32'(bus.jump_en_o),    32'(jmp));
    if (jmp) check("jump_addr", bus.jump_addr_o, ja);
    if (v) begin
      check("inst_addr", bus.inst_addr_o, head);
      check("inst",      bus.inst_o,      head ^ KEY);
    end
    if (pop) begin
      check("order", bus.inst_addr_o, exp_next);
      exp_next = head + 32'd4;
    end
    if (ex) exp_next = exa;

    if (ex) mq.delete();
    else begin
      if (push) mq.push_back(m_f1pc);
      if (pop)  mq.pop_front();
    end
    m_f1pc = pc;
    m_f1v  = !jmp;
  endtask

  initial begin
    int prob;
    bit r, rdy, ex;
    rst = 1'b1;
    bus.inst_ready_i   = 1'b0;
    bus.ex_jump_en_i   = 1'b0;
    bus.ex_jump_addr_i = 32'h0;
    m_f1v  = 1'b0;
    m_f1pc = 32'h0;
    exp_next = 32'h0;

    // Reset held two cycles
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Streaming with decode always ready
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    // Overflow with decode stalled, then drain
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    // Execute redirect with three entries held
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    // Redirect coincident with a full buffer
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    // Full buffer with pop and arrival together
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // Randomized traffic with varying decode pressure
    prob = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) prob = int'($urandom_range(10, 95));
      r   = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 99) < prob);
      ex  = !r && ($urandom_range(0, 15) == 0);
      step(r, rdy, ex, $urandom & 32'h0000_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
# ifetch_buf

Instruction fetch buffer between the PC register and decode. It consumes the free-running PC stream, issues reads to the synchronous instruction ROM, and queues returned instructions with their addresses for decode under a valid/ready handshake. The PC register has no stall input, so back-pressure works through its redirect port. On buffer overflow the block replays the dropped address as a jump. It also forwards execute-stage branch redirects and flushes wrong-path instructions.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_i  in  32  current PC from PC register; advances +4 per cycle unless redirected
- imem_addr_o  out  32  ROM read address; combinational copy of pc_i
- imem_rdata_i  in  32  ROM data; valid the cycle after its address
- ex_jump_en_i  in  1  execute-stage redirect request
- ex_jump_addr_i  in  32  execute-stage redirect target
- jump_en_o  out  1  redirect to PC register (combinational)
- jump_addr_o  out  32  redirect target
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  32  instruction at head
- inst_addr_o  out  32  address of inst_o
- inst_ready_i  in  1  decode accepts head

## Operation
- f1_pc and f1_valid are registered each cycle.
  - f1_pc <= pc_i.
  - f1_valid <= 0 after reset and in the cycle after any redirect; otherwise 1.
- Arrival: f1_valid=1 means imem_rdata_i/f1_pc is an arriving entry.
- Pop: inst_valid_o & inst_ready_i.
- Push: arrival & no redirect this cycle & (count<DEPTH or pop).
- Replay: arrival & count==DEPTH & !pop & !ex_jump_en_i. Drives jump_en_o=1 and jump_addr_o=f1_pc. The entry is dropped.
- Ex redirect: ex_jump_en_i=1.
  - jump_en_o=1, jump_addr_o=ex_jump_addr_i.
  - FIFO is cleared at the clock edge and the arrival is discarded.
  - inst_valid_o is forced to 0 that cycle, so no wrong-path pop.
- Priority: ex redirect over replay.
- count is clog2(DEPTH)+1 bits. Read/write pointers are clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop: count unchanged.

## Timing
- Reset values:
  - inst_valid_o=0, jump_en_o=0, count=0, pointers=0, f1_valid=0.
  - inst_o, inst_addr_o and jump_addr_o are don't-care while their valids are low.
- Latency from address issue to inst_valid_o: 2 cycles (addr t, data t+1, FIFO head t+2).
- Redirect in cycle t:
  - The arrival in t is dropped.
  - The arrival in t+1 (fetch issued at t) is killed via f1_valid=0.
  - The PC register outputs the target at t+1; its data arrives at t+2.
- No second replay can occur in t+1, since that arrival is killed.
- A replayed address re-arrives 2 cycles after the replay. If the FIFO is still full, it replays again.
- Ordering guarantee: instructions leave in strict address-stream order, with no duplicates or gaps, across any number of replays.
- Reset mid-operation clears all state at the next edge. No redirect is issued.

## Configuration
- IFETCH_BYPASS_EN defined:
  - When count==0 and an arrival is pushable, the arrival drives inst_valid_o/inst_o/inst_addr_o in the same cycle (latency 1).
  - If accepted, it is not written. Otherwise it is written normally.
- Undefined: outputs always come from the FIFO head (latency 2).

## Test plan
- Reset: rst=1 for 2 cycles with ROM active -> inst_valid_o=0, jump_en_o=0, count 0; first inst_addr_o after release is 0x0.
- Streaming: inst_ready_i=1, PC 0x0,0x4,0x8… with rdata=addr^0xA5A5A5A5 -> addresses delivered in order, one per cycle, at latency 2 (1 with IFETCH_BYPASS_EN), jump_en_o never high.
- Overflow replay: DEPTH=4, inst_ready_i=0 -> 0x0–0xC buffered; 0x10 arrival gives jump_en_o=1, jump_addr_o=0x10 for one cycle. Raising ready later delivers 0x10,0x14… with no duplicate.
- Ex redirect: FIFO holds 3 entries, ex_jump_en_i=1, addr 0x100 -> same-cycle jump_en_o=1/0x100, inst_valid_o=0; next valid inst_addr_o=0x100.
- Ex redirect coincident with overflow -> jump_addr_o=ex_jump_addr_i; replay suppressed.
- Full FIFO, pop and arrival same cycle -> no replay, count stays 4, arriving entry appended.
